// File: rtl/fsm_sched_if.sv
`timescale 1ns/1ps
// Bundle of requester inputs and worker status outputs for fsm_sched.
// The slave side is the scheduler; the master side is whoever drives the
// switch inputs and watches the status lines.
interface fsm_sched_if #(
    parameter int CNT_BITS = 4
);
    logic [1:0]          req;
    logic                tick;
    logic [1:0]          grant;
    logic                busy;
    logic                done;
    logic [CNT_BITS-1:0] run_cnt;
    logic [1:0]          state;

    modport master (
        output req,
        input  tick, grant, busy, done, run_cnt, state
    );

    modport slave (
        input  req,
        output tick, grant, busy, done, run_cnt, state
    );
endinterface

// File: rtl/fsm_sched.sv
`timescale 1ns/1ps
// fsm_sched: shares one slow worker between two switch-driven requesters.
// A free-running prescaler provides the slow tick. Raw requests are
// synchronized and edge-detected into a pending set. Pending jobs are
// granted round-robin and walked through ESPERA -> ARM -> FACA -> FIM.
module fsm_sched #(
    parameter int DIV_BITS  = 24,
    parameter int RUN_TICKS = 8,
    parameter int CNT_BITS  = 4
) (
    input  logic       clock,
    input  logic       reset,
    fsm_sched_if.slave bus
);
    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        ARM    = 2'd1,
        FACA   = 2'd2,
        FIM    = 2'd3
    } state_t;

    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(RUN_TICKS - 1);

    logic [DIV_BITS-1:0] presc_reg;
    logic                tick;
    logic [1:0]          rise;

    state_t              state_reg, state_next;
    logic [1:0]          pending_reg, pending_next;
    logic [1:0]          clear_mask;
    logic [1:0]          grant_reg, grant_next;
    logic [CNT_BITS-1:0] run_cnt_reg, run_cnt_next;
    logic                done_reg, done_next;
    logic                last_reg, last_next;
    logic                arm_entry_reg, arm_entry_next;
    logic                win;

    // Free-running prescaler; the all-ones count is the tick cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + DIV_BITS'(1);
        end
    end

    assign tick = &presc_reg;

    // Per-bit synchronizer and rising-edge detector for the raw switches.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            logic prev_reg;

            // Two flops to settle the asynchronous input, one to remember it.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                    prev_reg <= 1'b0;
                end else begin
                    meta_reg <= bus.req[gi];
                    sync_reg <= meta_reg;
                    prev_reg <= sync_reg;
                end
            end

            assign rise[gi] = sync_reg & ~prev_reg;
        end
    endgenerate

    // Round-robin pick: a lone request wins, a tie goes to the one not served last.
    always_comb begin
        win = 1'b0;
        case (pending_reg)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            default: win = ~last_reg;
        endcase
    end

    // Next-state and registered-output logic for the job sequencer.
    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        run_cnt_next   = run_cnt_reg;
        done_next      = 1'b0;
        last_next      = last_reg;
        arm_entry_next = 1'b0;
        clear_mask     = 2'b00;

        case (state_reg)
            ESPERA: begin
                if (pending_reg != 2'b00) begin
                    grant_next     = win ? 2'b10 : 2'b01;
                    clear_mask     = win ? 2'b10 : 2'b01;
                    last_next      = win;
                    arm_entry_next = 1'b1;
                    state_next     = ARM;
                end
            end
            ARM: begin
                // The first ARM cycle ignores a tick so the job always starts
                // on a fresh, full tick period.
                if (tick && !arm_entry_reg) begin
                    state_next   = FACA;
                    run_cnt_next = '0;
                end
            end
            FACA: begin
                if (tick) begin
                    if (run_cnt_reg == LAST_CNT) begin
                        state_next   = FIM;
                        run_cnt_next = '0;
                        grant_next   = 2'b00;
                        done_next    = 1'b1;
                    end else begin
                        run_cnt_next = run_cnt_reg + CNT_BITS'(1);
                    end
                end
            end
            FIM: begin
                state_next = ESPERA;
            end
            default: begin
                state_next = ESPERA;
            end
        endcase

        // A new edge overrides the clear of its own bit, so it is re-queued.
        pending_next = (pending_reg & ~clear_mask) | rise;
    end

    // Sequencer state and registered outputs; last starts at 1 so req[0] wins the first tie.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= ESPERA;
            pending_reg   <= 2'b00;
            grant_reg     <= 2'b00;
            run_cnt_reg   <= '0;
            done_reg      <= 1'b0;
            last_reg      <= 1'b1;
            arm_entry_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            grant_reg     <= grant_next;
            run_cnt_reg   <= run_cnt_next;
            done_reg      <= done_next;
            last_reg      <= last_next;
            arm_entry_reg <= arm_entry_next;
        end
    end

    assign bus.tick    = tick;
    assign bus.grant   = grant_reg;
    assign bus.busy    = (state_reg != ESPERA);
    assign bus.done    = done_reg;
    assign bus.run_cnt = run_cnt_reg;
    assign bus.state   = state_reg;

endmodule
